if_id_skid_reg: RTL and testbench
=================================

// Module: if_id_skid_reg
// PURPOSE
//  IF/ID pipeline stage register with a 2-entry skid buffer and valid/ready handshakes.
//  Sits between instruction fetch (PC+4, instruction) and decode.
//  Decode feeds imm_o (instruction bits [15:0]) straight into the sign-extend unit.
//  Decouples fetch from decode stalls without a combinational ready path, and
//  supports a branch/jump flush.
// PARAMETERS
//  PC_W      32            width of the PC+4 field
//  INSTR_W   32            width of the instruction field (must be >= 16)
//  NOP_INSTR 32'h0000_0000 instruction value loaded on reset/flush (sll $0,$0,0)
// PORTS
//  clk_i        in   1        clock; all state updates on rising edge
//  rst_i        in   1        reset, synchronous, active-high
//  flush_i      in   1        synchronous flush: discard all buffered entries
//  in_valid_i   in   1        fetch presents a valid entry
//  in_ready_o   out  1        stage can accept an entry this cycle
//  pc_plus4_i   in   PC_W     PC+4 of the fetched instruction
//  instr_i      in   INSTR_W  fetched instruction
//  out_valid_o  out  1        decode-side entry valid
//  out_ready_i  in   1        decode consumes the entry this cycle
//  pc_plus4_o   out  PC_W     PC+4 of the head entry
//  instr_o      out  INSTR_W  instruction of the head entry
//  imm_o        out  16       instr_o[15:0]; feeds the sign-extend unit
// BEHAVIOUR
//  - Interface: one clock (clk_i). Reset rst_i is synchronous and active-high.
//  - Storage: main reg (drives outputs) + skid reg. State is one of EMPTY, ONE, TWO.
//  - All outputs are registered or decoded from state only.
//    No combinational path from in_* to out_*, or from out_ready_i to in_ready_o.
//  - Reset: state=EMPTY, out_valid_o=0, in_ready_o=1, pc_plus4_o=0, instr_o=NOP_INSTR,
//    imm_o=NOP_INSTR[15:0]. Skid contents are cleared to the same values.
//  - Transfer events: acc = in_valid_i & in_ready_o; take = out_valid_o & out_ready_i.
//  - in_ready_o = (state != TWO). out_valid_o = (state != EMPTY).
//  - State transitions:
//    EMPTY: acc -> ONE, main <= input.
//    ONE:   acc & take  -> ONE, main <= input.
//           acc & !take -> TWO, skid <= input.
//           take & !acc -> EMPTY.
//           otherwise hold.
//    TWO:   take -> ONE, main <= skid. Otherwise hold. Input is never accepted in TWO.
//  - Ordering is strictly FIFO; entries are never duplicated or reordered.
//  - Latency: entry accepted in cycle N is presented with out_valid_o=1 in cycle N+1
//    if the stage was EMPTY, or the stage was ONE with take in cycle N.
//  - Throughput: 1 entry/cycle while out_ready_i=1.
//  - Data stability: while out_valid_o=1 and out_ready_i=0, pc_plus4_o and instr_o
//    hold constant.
//  - In EMPTY, data outputs hold their last value, or NOP/0 after reset or flush.
//  - flush_i=1: next state is EMPTY. main and skid are loaded with NOP_INSTR / 0.
//    Any acc or take in the same cycle is discarded.
//    flush_i dominates all other inputs except rst_i.
//  - rst_i=1 mid-operation dominates flush_i and all handshakes. Result equals the reset state.
//  - in_valid_i while in_ready_o=0: entry is not captured. Fetch must hold it.
// TESTING
//  T1 reset: rst_i=1 for 2 cycles with in_valid_i=1 -> out_valid_o=0, in_ready_o=1,
//     instr_o=32'h0, pc_plus4_o=0.
//  T2 streaming: out_ready_i=1; push instrs 0x2008_0005, 0x2009_FFFB, 0x0109_5020
//     in back-to-back cycles -> each appears 1 cycle later in order.
//     imm_o=0x0005, 0xFFFB, 0x5020.
//  T3 backpressure: out_ready_i=0; push A=0x2008_0001, B=0x2008_0002, C=0x2008_0003 ->
//     in_ready_o drops after B; C is held by fetch.
//     Raise out_ready_i -> outputs A, B, C in order, none lost.
//  T4 simultaneous: state ONE holding A, acc(B) & take in the same cycle ->
//     next cycle instr_o=B, state ONE, in_ready_o=1.
//  T5 flush: state TWO (A, B), flush_i=1 with in_valid_i=1 (C) and out_ready_i=1 ->
//     next cycle out_valid_o=0, instr_o=NOP_INSTR, C dropped, A not counted as consumed.
//  T6 reset vs flush: rst_i=1 and flush_i=1 in state ONE -> reset values.
//     Next accepted entry pc_plus4_i=32'h0000_0044 appears with pc_plus4_o=32'h44.

Source files
------------

// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline register with a 2-entry skid buffer and valid/ready handshakes.
// All outputs are registered or decoded from state; flush empties both entries.
module if_id_skid_reg #(
    parameter int unsigned        PC_W      = 32,
    parameter int unsigned        INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               flush_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [PC_W-1:0]    pc_plus4_i,
    input  logic [INSTR_W-1:0] instr_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PC_W-1:0]    pc_plus4_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic [15:0]        imm_o
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    main_pc_q, main_pc_d;
    logic [INSTR_W-1:0] main_instr_q, main_instr_d;
    logic [PC_W-1:0]    skid_pc_q, skid_pc_d;
    logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
    logic               acc, take;

    assign in_ready_o  = (state_q != TWO);
    assign out_valid_o = (state_q != EMPTY);
    assign pc_plus4_o  = main_pc_q;
    assign instr_o     = main_instr_q;
    assign imm_o       = main_instr_q[15:0];

    assign acc  = in_valid_i & in_ready_o;
    assign take = out_valid_o & out_ready_i;

    always_comb begin
        state_d      = state_q;
        main_pc_d    = main_pc_q;
        main_instr_d = main_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;

        unique case (state_q)
            EMPTY: begin
                if (acc) begin
                    state_d      = ONE;
                    main_pc_d    = pc_plus4_i;
                    main_instr_d = instr_i;
                end
            end
            ONE: begin
                if (acc && take) begin
                    main_pc_d    = pc_plus4_i;
                    main_instr_d = instr_i;
                end else if (acc) begin
                    state_d      = TWO;
                    skid_pc_d    = pc_plus4_i;
                    skid_instr_d = instr_i;
                end else if (take) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (take) begin
                    state_d      = ONE;
                    main_pc_d    = skid_pc_q;
                    main_instr_d = skid_instr_q;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush overrides any handshake decided above.
        if (flush_i) begin
            state_d      = EMPTY;
            main_pc_d    = '0;
            main_instr_d = NOP_INSTR;
            skid_pc_d    = '0;
            skid_instr_d = NOP_INSTR;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= EMPTY;
            main_pc_q    <= '0;
            main_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_instr_q <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            main_pc_q    <= main_pc_d;
            main_instr_q <= main_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
        end
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Bench for if_id_skid_reg: directed scenarios plus randomized traffic checked
// against a queue-based model of a 2-deep FIFO stage.
module tb_if_id_skid_reg;

    logic        clk = 1'b0;
    logic        rst_i, flush_i, in_valid_i, out_ready_i;
    logic        in_ready_o, out_valid_o;
    logic [31:0] pc_plus4_i, instr_i, pc_plus4_o, instr_o;
    logic [15:0] imm_o;

    int unsigned total = 0;
    int unsigned bad   = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] last_pc, last_instr;
    logic        exp_valid, exp_ready;
    logic [31:0] exp_pc, exp_instr;

    localparam logic [31:0] NOP = 32'h0000_0000;

    if_id_skid_reg #(
        .PC_W     (32),
        .INSTR_W  (32),
        .NOP_INSTR(NOP)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .pc_plus4_i (pc_plus4_i),
        .instr_i    (instr_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .pc_plus4_o (pc_plus4_o),
        .instr_o    (instr_o),
        .imm_o      (imm_o)
    );

    always #5 clk = ~clk;

    // Drive one cycle of inputs, advance the model at the edge, return 1 time unit later.
    task automatic cycle(input logic r, input logic f, input logic iv,
                         input logic [31:0] pc, input logic [31:0] ins, input logic ordy);
        logic acc, take;
        ent_t e;
        @(negedge clk);
        rst_i = r; flush_i = f; in_valid_i = iv;
        pc_plus4_i = pc; instr_i = ins; out_ready_i = ordy;
        @(posedge clk);
        if (r || f) begin
            mq.delete();
            last_pc    = 32'h0;
            last_instr = NOP;
        end else begin
            acc  = iv && (mq.size() < 2);
            take = (mq.size() > 0) && ordy;
            if (take) begin
                e          = mq.pop_front();
                last_pc    = e.pc;
                last_instr = e.instr;
            end
            if (acc) mq.push_back('{pc: pc, instr: ins});
        end
        exp_valid = (mq.size() != 0);
        exp_ready = (mq.size() < 2);
        exp_pc    = (mq.size() != 0) ? mq[0].pc    : last_pc;
        exp_instr = (mq.size() != 0) ? mq[0].instr : last_instr;
        #1;
    endtask

    task automatic test_reset;
        cycle(1'b1, 1'b0, 1'b1, 32'h1234, 32'hDEAD_BEEF, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 32'h1238, 32'hCAFE_F00D, 1'b0);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", out_valid_o); end
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready_o); end
        total++; if (instr_o !== NOP) begin bad++; $display("FAIL reset_instr got=%h exp=%h", instr_o, NOP); end
        total++; if (pc_plus4_o !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", pc_plus4_o); end
        total++; if (imm_o !== NOP[15:0]) begin bad++; $display("FAIL reset_imm got=%h exp=%h", imm_o, NOP[15:0]); end
    endtask

    task automatic test_streaming;
        logic [31:0] tv[3];
        logic [31:0] cur;
        tv[0] = 32'h2008_0005; tv[1] = 32'h2009_FFFB; tv[2] = 32'h0109_5020;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4 * i), tv[i], 1'b1);
            cur = tv[i];
            total++; if (out_valid_o !== 1'b1) begin bad++; $display("FAIL stream_valid%0d got=%b exp=1", i, out_valid_o); end
            total++; if (instr_o !== cur) begin bad++; $display("FAIL stream_instr%0d got=%h exp=%h", i, instr_o, cur); end
            total++; if (imm_o !== cur[15:0]) begin bad++; $display("FAIL stream_imm%0d got=%h exp=%h", i, imm_o, cur[15:0]); end
            total++; if (pc_plus4_o !== 32'h100 + 32'(4 * i)) begin bad++; $display("FAIL stream_pc%0d got=%h exp=%h", i, pc_plus4_o, 32'h100 + 32'(4 * i)); end
        end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL stream_drain_valid got=%b exp=0", out_valid_o); end
        total++; if (instr_o !== 32'h0109_5020) begin bad++; $display("FAIL stream_hold_instr got=%h exp=01095020", instr_o); end
    endtask

    task automatic test_backpressure;
        cycle(1'b0, 1'b0, 1'b1, 32'h200, 32'h2008_0001, 1'b0);
        total++; if (in_ready_o !== 1'b1 || instr_o !== 32'h2008_0001) begin bad++; $display("FAIL bp_a got ready=%b instr=%h exp ready=1 instr=20080001", in_ready_o, instr_o); end
        cycle(1'b0, 1'b0, 1'b1, 32'h204, 32'h2008_0002, 1'b0);
        total++; if (in_ready_o !== 1'b0 || instr_o !== 32'h2008_0001) begin bad++; $display("FAIL bp_full got ready=%b instr=%h exp ready=0 instr=20080001", in_ready_o, instr_o); end
        cycle(1'b0, 1'b0, 1'b1, 32'h208, 32'h2008_0003, 1'b0);
        total++; if (in_ready_o !== 1'b0 || instr_o !== 32'h2008_0001 || pc_plus4_o !== 32'h200) begin bad++; $display("FAIL bp_stable got ready=%b instr=%h pc=%h exp ready=0 instr=20080001 pc=200", in_ready_o, instr_o, pc_plus4_o); end
        cycle(1'b0, 1'b0, 1'b1, 32'h208, 32'h2008_0003, 1'b1);
        total++; if (in_ready_o !== 1'b1 || instr_o !== 32'h2008_0002 || pc_plus4_o !== 32'h204) begin bad++; $display("FAIL bp_b got ready=%b instr=%h pc=%h exp ready=1 instr=20080002 pc=204", in_ready_o, instr_o, pc_plus4_o); end
        cycle(1'b0, 1'b0, 1'b1, 32'h208, 32'h2008_0003, 1'b1);
        total++; if (out_valid_o !== 1'b1 || instr_o !== 32'h2008_0003) begin bad++; $display("FAIL bp_c got valid=%b instr=%h exp valid=1 instr=20080003", out_valid_o, instr_o); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL bp_drain got valid=%b exp=0", out_valid_o); end
    endtask

    task automatic test_simultaneous;
        cycle(1'b0, 1'b0, 1'b1, 32'h300, 32'hAAAA_0001, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h304, 32'hBBBB_0002, 1'b1);
        total++; if (instr_o !== 32'hBBBB_0002) begin bad++; $display("FAIL simul_instr got=%h exp=bbbb0002", instr_o); end
        total++; if (out_valid_o !== 1'b1 || in_ready_o !== 1'b1) begin bad++; $display("FAIL simul_state got valid=%b ready=%b exp valid=1 ready=1", out_valid_o, in_ready_o); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL simul_drain got=%b exp=0", out_valid_o); end
    endtask

    task automatic test_flush;
        cycle(1'b0, 1'b0, 1'b1, 32'h400, 32'h1111_0001, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 32'h404, 32'h2222_0002, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 32'h408, 32'h3333_0003, 1'b1);
        total++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin bad++; $display("FAIL flush_state got valid=%b ready=%b exp valid=0 ready=1", out_valid_o, in_ready_o); end
        total++; if (instr_o !== NOP || pc_plus4_o !== 32'h0) begin bad++; $display("FAIL flush_data got instr=%h pc=%h exp instr=%h pc=0", instr_o, pc_plus4_o, NOP); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL flush_c_dropped got valid=%b exp=0", out_valid_o); end
        cycle(1'b0, 1'b0, 1'b1, 32'h40C, 32'h4444_0004, 1'b0);
        total++; if (instr_o !== 32'h4444_0004 || in_ready_o !== 1'b1) begin bad++; $display("FAIL flush_next got instr=%h ready=%b exp instr=44440004 ready=1", instr_o, in_ready_o); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_vs_flush;
        cycle(1'b0, 1'b0, 1'b1, 32'h500, 32'h5555_0005, 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 32'h504, 32'h6666_0006, 1'b1);
        total++; if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || instr_o !== NOP || pc_plus4_o !== 32'h0) begin bad++; $display("FAIL rstflush got valid=%b ready=%b instr=%h pc=%h exp 0 1 %h 0", out_valid_o, in_ready_o, instr_o, pc_plus4_o, NOP); end
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h2008_0044, 1'b0);
        total++; if (pc_plus4_o !== 32'h44 || out_valid_o !== 1'b1) begin bad++; $display("FAIL rstflush_next got pc=%h valid=%b exp pc=44 valid=1", pc_plus4_o, out_valid_o); end
        cycle(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic test_random;
        logic r, f, iv, ordy;
        for (int n = 0; n < 600; n++) begin
            r    = ($urandom_range(0, 59) == 0);
            f    = ($urandom_range(0, 24) == 0);
            iv   = ($urandom_range(0, 1) == 1);
            ordy = ($urandom_range(0, 9) < 6);
            cycle(r, f, iv, $urandom, $urandom, ordy);
            total++; if (out_valid_o !== exp_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", n, out_valid_o, exp_valid); end
            total++; if (in_ready_o !== exp_ready) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", n, in_ready_o, exp_ready); end
            total++; if (pc_plus4_o !== exp_pc) begin bad++; $display("FAIL rnd_pc cyc=%0d got=%h exp=%h", n, pc_plus4_o, exp_pc); end
            total++; if (instr_o !== exp_instr) begin bad++; $display("FAIL rnd_instr cyc=%0d got=%h exp=%h", n, instr_o, exp_instr); end
            total++; if (imm_o !== exp_instr[15:0]) begin bad++; $display("FAIL rnd_imm cyc=%0d got=%h exp=%h", n, imm_o, exp_instr[15:0]); end
        end
    endtask

    initial begin
        rst_i = 1'b1; flush_i = 1'b0; in_valid_i = 1'b1; out_ready_i = 1'b0;
        pc_plus4_i = '0; instr_i = '0;
        last_pc = '0; last_instr = NOP;
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_reset_vs_flush();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
